// File: rtl/fila_instrucoes_classes.sv
// In-order instruction queue between fetch and dispatch.
// Accepted instructions are sorted into an R-class buffer (ADD/SUB) or an
// I-class buffer (LD/ST); a program-order tag queue remembers the class of
// every entry so dispatch always takes the oldest entry, either
// unconditionally (Pop) or only when the oldest entry matches a class
// (Pop_R / Pop_I). A gated pop never skips past an older entry of the other
// class.
module fila_instrucoes_classes #(
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 3,
  parameter int DEPTH_R = 8,
  parameter int DEPTH_I = 8,
  parameter int OP_ADD  = 2,
  parameter int OP_SUB  = 3,
  parameter int OP_LD   = 4,
  parameter int OP_ST   = 5,
  parameter logic [DATA_W-1:0] SEM_VALOR = DATA_W'(16'h0005)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Flush,
  input  logic                      In_valid,
  input  logic [DATA_W-1:0]         In_data,
  output logic                      In_ready,
  input  logic                      Pop,
  input  logic                      Pop_R,
  input  logic                      Pop_I,
  output logic [DATA_W-1:0]         Instrucao_Despachada,
  output logic                      Out_valid,
  output logic                      Out_tipo,
  output logic                      Illegal,
  output logic [$clog2(DEPTH_R):0]  Count_R,
  output logic [$clog2(DEPTH_I):0]  Count_I,
  output logic                      Full,
  output logic                      Empty
);

  // Pointer / counter geometry. The order queue holds one tag per stored
  // entry, so its depth is the sum of both buffers and it can never
  // overflow on its own; its depth need not be a power of two, so its
  // pointers wrap explicitly.
  localparam int PTR_R_W = $clog2(DEPTH_R);
  localparam int PTR_I_W = $clog2(DEPTH_I);
  localparam int CNT_R_W = PTR_R_W + 1;
  localparam int CNT_I_W = PTR_I_W + 1;
  localparam int DEPTH_O = DEPTH_R + DEPTH_I;
  localparam int PTR_O_W = $clog2(DEPTH_O);

  localparam logic [CNT_R_W-1:0] CNT_R_MAX = CNT_R_W'(DEPTH_R);
  localparam logic [CNT_I_W-1:0] CNT_I_MAX = CNT_I_W'(DEPTH_I);
  localparam logic [PTR_O_W-1:0] PTR_O_LAST = PTR_O_W'(DEPTH_O - 1);

  localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(OP_ADD);
  localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(OP_SUB);
  localparam logic [OPC_W-1:0] OPC_LD  = OPC_W'(OP_LD);
  localparam logic [OPC_W-1:0] OPC_ST  = OPC_W'(OP_ST);

  // Class tag encoding in the order queue and on Out_tipo.
  localparam logic TAG_R = 1'b0;
  localparam logic TAG_I = 1'b1;

  // Storage: two class buffers plus the program-order tag queue.
  logic [DATA_W-1:0] r_mem [DEPTH_R];
  logic [DATA_W-1:0] i_mem [DEPTH_I];
  logic              o_mem [DEPTH_O];

  logic [PTR_R_W-1:0] r_head_reg, r_tail_reg;
  logic [PTR_I_W-1:0] i_head_reg, i_tail_reg;
  logic [PTR_O_W-1:0] o_head_reg, o_tail_reg;
  logic [CNT_R_W-1:0] count_r_reg, count_r_next;
  logic [CNT_I_W-1:0] count_i_reg, count_i_next;

  logic [OPC_W-1:0] in_opcode;
  logic             in_is_r, in_is_i;
  logic             push_fire, push_r, push_i, push_bad;
  logic             head_tag, queue_has, pop_req, pop_fire, pop_r, pop_i;

  // Order-queue pointer increment with wrap at an arbitrary depth.
  function automatic logic [PTR_O_W-1:0] o_inc(input logic [PTR_O_W-1:0] p);
    return (p == PTR_O_LAST) ? '0 : p + PTR_O_W'(1);
  endfunction

  // Fetch side: classify the presented instruction and decide acceptance.
  always_comb begin
    in_opcode = In_data[DATA_W-1 -: OPC_W];
    in_is_r   = (in_opcode == OPC_ADD) || (in_opcode == OPC_SUB);
    in_is_i   = (in_opcode == OPC_LD)  || (in_opcode == OPC_ST);
    // Readiness only looks at the current occupancy: a pop in the same
    // cycle does not free a slot early, keeping In_ready off the pop path.
    // Unknown opcodes are always taken so they can be reported and dropped.
    if (Flush)
      In_ready = 1'b0;
    else if (in_is_r)
      In_ready = (count_r_reg != CNT_R_MAX);
    else if (in_is_i)
      In_ready = (count_i_reg != CNT_I_MAX);
    else
      In_ready = 1'b1;
    push_fire = In_valid && In_ready;
    push_r    = push_fire && in_is_r;
    push_i    = push_fire && in_is_i;
    push_bad  = push_fire && !in_is_r && !in_is_i;
  end

  // Dispatch side: every request targets the oldest entry. Pop wins over
  // the gated requests, but since all of them address the same head entry
  // the priority only decides whether the head may leave, never which one.
  always_comb begin
    head_tag  = o_mem[o_head_reg];
    queue_has = (count_r_reg != '0) || (count_i_reg != '0);
    pop_req   = Pop
             || (Pop_R && (head_tag == TAG_R))
             || (Pop_I && (head_tag == TAG_I));
    pop_fire  = !Flush && queue_has && pop_req;
    pop_r     = pop_fire && (head_tag == TAG_R);
    pop_i     = pop_fire && (head_tag == TAG_I);
  end

  // Occupancy after this edge; push and pop of the same class cancel out.
  always_comb begin
    count_r_next = count_r_reg + CNT_R_W'(push_r) - CNT_R_W'(pop_r);
    count_i_next = count_i_reg + CNT_I_W'(push_i) - CNT_I_W'(pop_i);
  end

  // Storage writes: data into its class buffer and its tag into the order queue.
  always_ff @(posedge Clock) begin
    if (push_r)
      r_mem[r_tail_reg] <= In_data;
    if (push_i)
      i_mem[i_tail_reg] <= In_data;
    if (push_r || push_i)
      o_mem[o_tail_reg] <= push_i ? TAG_I : TAG_R;
  end

  // Pointers, counts, status flags and the registered dispatch outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_head_reg           <= '0;
      r_tail_reg           <= '0;
      i_head_reg           <= '0;
      i_tail_reg           <= '0;
      o_head_reg           <= '0;
      o_tail_reg           <= '0;
      count_r_reg          <= '0;
      count_i_reg          <= '0;
      Instrucao_Despachada <= SEM_VALOR;
      Out_valid            <= 1'b0;
      Out_tipo             <= TAG_R;
      Illegal              <= 1'b0;
      Full                 <= 1'b0;
      Empty                <= 1'b1;
    end else if (Flush) begin
      // Flush discards everything, including any push or pop this cycle.
      // Out_tipo keeps its last value; only the data returns to idle.
      r_head_reg           <= '0;
      r_tail_reg           <= '0;
      i_head_reg           <= '0;
      i_tail_reg           <= '0;
      o_head_reg           <= '0;
      o_tail_reg           <= '0;
      count_r_reg          <= '0;
      count_i_reg          <= '0;
      Instrucao_Despachada <= SEM_VALOR;
      Out_valid            <= 1'b0;
      Illegal              <= 1'b0;
      Full                 <= 1'b0;
      Empty                <= 1'b1;
    end else begin
      if (push_r)
        r_tail_reg <= r_tail_reg + PTR_R_W'(1);
      if (push_i)
        i_tail_reg <= i_tail_reg + PTR_I_W'(1);
      if (push_r || push_i)
        o_tail_reg <= o_inc(o_tail_reg);

      if (pop_r)
        r_head_reg <= r_head_reg + PTR_R_W'(1);
      if (pop_i)
        i_head_reg <= i_head_reg + PTR_I_W'(1);
      if (pop_fire) begin
        o_head_reg           <= o_inc(o_head_reg);
        Instrucao_Despachada <= (head_tag == TAG_I) ? i_mem[i_head_reg]
                                                    : r_mem[r_head_reg];
        Out_tipo             <= head_tag;
      end

      count_r_reg <= count_r_next;
      count_i_reg <= count_i_next;
      Full        <= (count_r_next == CNT_R_MAX) || (count_i_next == CNT_I_MAX);
      Empty       <= (count_r_next == '0) && (count_i_next == '0);
      Out_valid   <= pop_fire;
      Illegal     <= push_bad;
    end
  end

  assign Count_R = count_r_reg;
  assign Count_I = count_i_reg;

endmodule

// File: tb/tb_fila_instrucoes_classes.sv
// Bench for fila_instrucoes_classes: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_fila_instrucoes_classes;

  localparam logic [15:0] SEM = 16'h0005;

  logic        Clock, Reset, Flush, In_valid, In_ready;
  logic [15:0] In_data;
  logic        Pop, Pop_R, Pop_I;
  logic [15:0] Instrucao_Despachada;
  logic        Out_valid, Out_tipo, Illegal, Full, Empty;
  logic [3:0]  Count_R, Count_I;

  fila_instrucoes_classes dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
    .Pop(Pop), .Pop_R(Pop_R), .Pop_I(Pop_I),
    .Instrucao_Despachada(Instrucao_Despachada),
    .Out_valid(Out_valid), .Out_tipo(Out_tipo), .Illegal(Illegal),
    .Count_R(Count_R), .Count_I(Count_I), .Full(Full), .Empty(Empty)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program-order queue of {class, data}; class 1 = I.
  logic [16:0] mq[$];
  logic [15:0] e_data;
  logic        e_valid, e_tipo, e_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = R-class, 1 = I-class, 2 = unknown opcode.
  function automatic int cls_of(input logic [15:0] d);
    logic [2:0] op;
    op = d[15:13];
    if (op == 3'd2 || op == 3'd3) return 0;
    if (op == 3'd4 || op == 3'd5) return 1;
    return 2;
  endfunction

  function automatic int cnt(input int c);
    int n = 0;
    foreach (mq[k]) if (int'(mq[k][16]) == c) n++;
    return n;
  endfunction

  function automatic logic m_ready();
    int c;
    if (Flush) return 1'b0;
    c = cls_of(In_data);
    if (c == 0) return cnt(0) < 8;
    if (c == 1) return cnt(1) < 8;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    e_data  = SEM;
    e_valid = 1'b0;
    e_tipo  = 1'b0;
    e_ill   = 1'b0;
  endtask

  task automatic check_outputs();
    check("data",    Instrucao_Despachada, e_data);
    check("valid",   Out_valid, e_valid);
    check("tipo",    Out_tipo,  e_tipo);
    check("illegal", Illegal,   e_ill);
    check("count_r", Count_R,   cnt(0));
    check("count_i", Count_I,   cnt(1));
    check("full",    Full,      (cnt(0) == 8) || (cnt(1) == 8));
    check("empty",   Empty,     mq.size() == 0);
  endtask

  // One clock with the currently driven inputs: check In_ready before the
  // edge, advance the model, then check the registered outputs after it.
  task automatic cycle();
    logic        r;
    logic [16:0] h;
    int          c;
    #1;
    r = m_ready();
    check("in_ready", In_ready, r);
    c = cls_of(In_data);
    @(posedge Clock);
    #1;
    if (Flush) begin
      mq.delete();
      e_valid = 1'b0;
      e_ill   = 1'b0;
      e_data  = SEM;
    end else begin
      e_valid = 1'b0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (Pop || (Pop_R && !h[16]) || (Pop_I && h[16])) begin
          void'(mq.pop_front());
          e_valid = 1'b1;
          e_data  = h[15:0];
          e_tipo  = h[16];
        end
      end
      e_ill = In_valid && r && (c == 2);
      if (In_valid && r && (c != 2)) mq.push_back({(c == 1), In_data});
    end
    check_outputs();
    $display("[TB] t=%0t v=%0b d=%h pop=%0b%0b%0b fl=%0b -> out=%h ov=%0b tipo=%0b ill=%0b cr=%0d ci=%0d",
             $time, In_valid, In_data, Pop, Pop_R, Pop_I, Flush,
             Instrucao_Despachada, Out_valid, Out_tipo, Illegal, Count_R, Count_I);
  endtask

  task automatic drv(input logic v, input logic [15:0] d, input logic p,
                     input logic pr, input logic pi, input logic f);
    In_valid = v; In_data = d; Pop = p; Pop_R = pr; Pop_I = pi; Flush = f;
    cycle();
  endtask

  task automatic push(input logic [15:0] d);
    drv(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    drv(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Flush = 1'b0; In_valid = 1'b0; In_data = '0;
    Pop = 1'b0; Pop_R = 1'b0; Pop_I = 1'b0;
    model_reset();
    #12;
    check_outputs();
    #1 Reset = 1'b0;

    // Basic push/pop order across classes.
    push(16'h4001); push(16'h8002); push(16'h6003);
    pop1(); pop1(); pop1();

    // Gated pop must not bypass an older I entry.
    push(16'h8010); push(16'h4011);
    drv(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // R buffer full; 9th ADD refused, LD still accepted.
    for (int i = 0; i < 9; i++) push(16'h4100 + 16'(i));
    push(16'h8100);
    for (int i = 0; i < 9; i++) pop1();

    // Unknown opcode: accepted, dropped, Illegal pulses once.
    push(16'hE000);
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap-around with both buffers full.
    for (int i = 0; i < 8; i++) begin
      push(16'h4200 + 16'(i));
      push(16'h8200 + 16'(i));
    end
    for (int i = 0; i < 4; i++) pop1();
    for (int i = 0; i < 2; i++) begin
      push(16'h6300 + 16'(i));
      push(16'hA300 + 16'(i));
    end
    for (int i = 0; i < 16; i++) pop1();

    // Flush together with Pop.
    push(16'h4400); push(16'h8400); push(16'h6400);
    drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of traffic.
    push(16'h4500); push(16'h8500); pop1();
    In_valid = 1'b1; In_data = 16'h4501; Pop = 1'b1;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge Clock);
    #1;
    check_outputs();
    Reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int          sel;
      int          phase;
      logic [2:0]  op;
      logic [12:0] lo;
      sel = $urandom_range(0, 9);
      if (sel < 2)      op = 3'd2;
      else if (sel < 4) op = 3'd3;
      else if (sel < 6) op = 3'd4;
      else if (sel < 8) op = 3'd5;
      else              op = 3'($urandom);
      lo = 13'($urandom);
      phase = (i / 200) % 3;
      drv(($urandom_range(0, 3) != 0), {op, lo},
          ($urandom_range(0, 5) < phase),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
